// File: rtl/spi_controller.sv
// SPI master (mode 0, MSB first) behind a 4-register bus interface.
// All state advances on the falling edge of i_clk; i_rst is async active-low.
module spi_controller (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cs,
    input  logic       i_rwb,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_spi_cs,
    output logic       o_spi_clk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t     state_q, state_d;
    logic       csen_q, csen_d;
    logic       done_q, done_d;
    logic [7:0] clkdiv_q, clkdiv_d;
    logic [7:0] div_q, div_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] edge_q, edge_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rxdata_q, rxdata_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;

    logic wr_en, rd_en, busy;

    assign wr_en = i_cs & ~i_rwb;
    assign rd_en = i_cs & i_rwb;
    assign busy  = (state_q == ST_SHIFT);

    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            csen_q   <= 1'b0;
            done_q   <= 1'b0;
            clkdiv_q <= 8'h03;
            div_q    <= 8'h00;
            cnt_q    <= 8'h00;
            edge_q   <= 4'h0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
            rxdata_q <= 8'h00;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            csen_q   <= csen_d;
            done_q   <= done_d;
            clkdiv_q <= clkdiv_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rxdata_q <= rxdata_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        csen_d   = csen_q;
        done_d   = done_q;
        clkdiv_d = clkdiv_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rxdata_d = rxdata_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;

        if (wr_en && i_addr == 2'd1) csen_d   = i_data[0];
        if (wr_en && i_addr == 2'd2) clkdiv_d = i_data;
        // Completion below overrides this clear when both land on one edge.
        if (rd_en && i_addr == 2'd0) done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_en && i_addr == 2'd0) begin
                    state_d = ST_SHIFT;
                    tx_d    = i_data;
                    mosi_d  = i_data[7];
                    div_d   = clkdiv_q;
                    cnt_d   = 8'h00;
                    edge_d  = 4'h0;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d  = 8'h00;
                    edge_d = edge_q + 4'd1;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], i_spi_miso};
                    end else if (edge_q == 4'd15) begin
                        sclk_d   = 1'b0;
                        rxdata_d = rx_q;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_data = 8'h00;
        if (rd_en) begin
            case (i_addr)
                2'd0:    o_data = rxdata_q;
                2'd1:    o_data = {busy, done_q, 5'b00000, csen_q};
                2'd2:    o_data = clkdiv_q;
                default: o_data = 8'h00;
            endcase
        end
    end

    assign o_spi_cs   = ~csen_q;
    assign o_spi_clk  = sclk_q;
    assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a timing model driven by edge counts since transfer
// start, checked every cycle, plus directed transfers with literal expectations.
module tb_spi_controller;

    logic       i_clk = 1'b1;
    logic       i_rst;
    logic       i_cs, i_rwb;
    logic [1:0] i_addr;
    logic [7:0] i_data, o_data;
    logic       o_spi_cs, o_spi_clk, o_spi_mosi, i_spi_miso;
    logic       loop_mode = 1'b0;
    logic       miso_const = 1'b0;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    assign i_spi_miso = loop_mode ? o_spi_mosi : miso_const;

    always #5 i_clk = ~i_clk;

    spi_controller dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cs       (i_cs),
        .i_rwb      (i_rwb),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_spi_cs   (o_spi_cs),
        .o_spi_clk  (o_spi_clk),
        .o_spi_mosi (o_spi_mosi),
        .i_spi_miso (i_spi_miso)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_n counts falling edges since the accepting edge.
    bit         m_busy = 0, m_done = 0, m_csen = 0;
    int         m_n = 0;
    logic [7:0] m_byte = 8'h00, m_div = 8'h00, m_clkdiv = 8'h03;
    logic [7:0] m_rxdata = 8'h00, m_rxnext = 8'h00;
    logic       m_mosi = 1'b0;
    bit         m_fin;

    always @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_busy = 0; m_done = 0; m_csen = 0; m_mosi = 1'b0;
            m_rxdata = 8'h00; m_clkdiv = 8'h03; m_n = 0;
        end else begin
            m_fin = 0;
            if (m_busy) begin
                m_n++;
                if (m_n == 16 * (int'(m_div) + 1)) begin
                    m_busy = 0; m_done = 1; m_rxdata = m_rxnext;
                    m_mosi = m_byte[0]; m_fin = 1;
                end
            end else if (i_cs && !i_rwb && i_addr == 2'd0) begin
                m_busy = 1; m_n = 0; m_byte = i_data; m_div = m_clkdiv;
                m_rxnext = loop_mode ? i_data : {8{miso_const}};
            end
            if (i_cs && !i_rwb && i_addr == 2'd1) m_csen = i_data[0];
            if (i_cs && !i_rwb && i_addr == 2'd2) m_clkdiv = i_data;
            if (i_cs && i_rwb && i_addr == 2'd0 && !m_fin) m_done = 0;
        end
    end

    function automatic logic exp_sclk();
        int d = int'(m_div) + 1;
        return m_busy ? logic'((m_n / d) % 2) : 1'b0;
    endfunction

    function automatic logic exp_mosi();
        int k = m_n / (2 * (int'(m_div) + 1));
        return m_busy ? m_byte[7 - k] : m_mosi;
    endfunction

    function automatic logic [7:0] exp_odata();
        if (!(i_cs && i_rwb)) return 8'h00;
        case (i_addr)
            2'd0:    return m_rxdata;
            2'd1:    return {m_busy, m_done, 5'b00000, m_csen};
            2'd2:    return m_clkdiv;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge i_clk) begin
        #2;
        if (cmp_en) begin
            chk("cyc_sclk", o_spi_clk, exp_sclk());
            chk("cyc_mosi", o_spi_mosi, exp_mosi());
            chk("cyc_cs", o_spi_cs, !m_csen);
            chk("cyc_odata", o_data, exp_odata());
        end
    end

    task automatic bus(input logic cs, input logic rwb, input logic [1:0] a, input logic [7:0] d);
        @(posedge i_clk);
        i_cs = cs; i_rwb = rwb; i_addr = a; i_data = d;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string nm);
        bus(1'b1, 1'b1, a, 8'h00);
        #1;
        chk(nm, o_data, exp);
    endtask

    // sp_kind: 1 = DATA write 0x3C at cycle sp_at, 2 = RXDATA read at cycle sp_at
    task automatic run_xfer(input logic [7:0] d, input int sp_at, input int sp_kind,
                            output int busy_cyc, output logic [7:0] mbyte,
                            output int hi_run, output int rises, output logic [7:0] st0);
        logic prev = 1'b0;
        int   hi = 0;
        bit   fin = 0;
        busy_cyc = 0; mbyte = 8'h00; hi_run = 0; rises = 0; st0 = 8'h00;
        bus(1'b1, 1'b0, 2'd0, d);
        for (int i = 0; i < 300; i++) begin
            if (i == sp_at && sp_kind == 1) bus(1'b1, 1'b0, 2'd0, 8'h3C);
            else if (i == sp_at && sp_kind == 2) bus(1'b1, 1'b1, 2'd0, 8'h00);
            else bus(1'b1, 1'b1, 2'd1, 8'h00);
            #1;
            if (o_spi_clk && !prev) begin
                mbyte = {mbyte[6:0], o_spi_mosi};
                rises++;
            end
            if (o_spi_clk) hi++;
            else if (hi > 0 && hi_run == 0) hi_run = hi;
            prev = o_spi_clk;
            if (i == 0) st0 = o_data;
            if (i == sp_at || o_data[7]) busy_cyc++;
            else begin
                fin = 1;
                break;
            end
        end
        chk("xfer_completes", fin, 1'b1);
    endtask

    int         bc, hr, nr;
    logic [7:0] mb, s0;

    initial begin
        i_rst = 1'b1; i_cs = 1'b0; i_rwb = 1'b0; i_addr = 2'd0; i_data = 8'h00;
        #1 i_rst = 1'b0;
        cmp_en = 1;
        repeat (2) @(posedge i_clk);
        i_rst = 1'b1;

        rd_chk(2'd1, 8'h00, "rst_status");
        rd_chk(2'd2, 8'h03, "rst_clkdiv");
        rd_chk(2'd0, 8'h00, "rst_rxdata");
        chk("rst_spi_cs", o_spi_cs, 1'b1);
        chk("rst_spi_clk", o_spi_clk, 1'b0);

        // loopback, CLKDIV=0
        loop_mode = 1'b1;
        bus(1'b1, 1'b0, 2'd1, 8'hFF);
        bus(1'b1, 1'b0, 2'd2, 8'h00);
        run_xfer(8'hA5, -1, 0, bc, mb, hr, nr, s0);
        chk("lb_spi_cs", o_spi_cs, 1'b0);
        chk("lb_status_busy", s0, 8'hC1 & 8'hBF);
        chk("lb_busy_cycles", 8'(bc), 8'd16);
        chk("lb_mosi_bits", mb, 8'hA5);
        chk("lb_pulses", 8'(nr), 8'd8);
        chk("lb_high_len", 8'(hr), 8'd1);
        rd_chk(2'd1, 8'h41, "lb_status_after");
        rd_chk(2'd0, 8'hA5, "lb_rxdata");
        rd_chk(2'd1, 8'h01, "lb_done_cleared");

        // divider: CLKDIV=3, MISO held high
        loop_mode = 1'b0; miso_const = 1'b1;
        bus(1'b1, 1'b0, 2'd2, 8'h03);
        run_xfer(8'h00, -1, 0, bc, mb, hr, nr, s0);
        chk("div_busy_cycles", 8'(bc), 8'd64);
        chk("div_high_len", 8'(hr), 8'd4);
        chk("div_mosi_bits", mb, 8'h00);
        rd_chk(2'd0, 8'hFF, "div_rxdata");

        // second DATA write while busy is dropped
        loop_mode = 1'b1;
        bus(1'b1, 1'b0, 2'd2, 8'h00);
        run_xfer(8'h81, 3, 1, bc, mb, hr, nr, s0);
        chk("bw_mosi_bits", mb, 8'h81);
        chk("bw_busy_cycles", 8'(bc), 8'd16);
        rd_chk(2'd0, 8'h81, "bw_rxdata");

        // RXDATA read on the completion edge: DONE must survive
        run_xfer(8'h5A, 15, 2, bc, mb, hr, nr, s0);
        rd_chk(2'd1, 8'h41, "coinc_done_kept");
        rd_chk(2'd0, 8'h5A, "coinc_rxdata");

        // reset during bit 3 (CLKDIV=3)
        loop_mode = 1'b0;
        bus(1'b1, 1'b0, 2'd2, 8'h03);
        bus(1'b1, 1'b0, 2'd0, 8'hC3);
        for (int i = 0; i < 28; i++) bus(1'b1, 1'b1, 2'd1, 8'h00);
        #1;
        chk("pre_rst_busy", o_data[7], 1'b1);
        @(posedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_status", o_data, 8'h00);
        chk("mid_rst_sclk", o_spi_clk, 1'b0);
        chk("mid_rst_cs", o_spi_cs, 1'b1);
        repeat (2) @(posedge i_clk);
        i_rst = 1'b1;
        rd_chk(2'd0, 8'h00, "post_rst_rxdata");
        rd_chk(2'd2, 8'h03, "post_rst_clkdiv");
        rd_chk(2'd1, 8'h00, "post_rst_status");
        bus(1'b0, 1'b0, 2'd0, 8'h00);
        #1;
        chk("idle_odata", o_data, 8'h00);

        repeat (2) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
